// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults and helpers for the serial pattern detector
package seq_det_pkg;

    localparam int         DEF_PAT_LEN   = 6;
    localparam logic [5:0] DEF_PAT_RESET = 6'b110011;
    localparam int         DEF_CNT_W     = 8;

    // Bits needed to hold a fill count ranging 0..pat_len inclusive.
    function automatic int fill_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter that sticks at all-ones until reset
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !sat) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = &cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - serial bit-pattern detector with loadable pattern and match counter
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN   = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PAT_RESET = PAT_LEN'(DEF_PAT_RESET),
    parameter int                 CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               z,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    localparam int             FW       = fill_width(PAT_LEN);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               z_q,    z_d;
    logic [FW-1:0]      fill_inc;
    logic               match;

    always_comb begin
        pat_d    = pat_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        z_d      = 1'b0;
        match    = 1'b0;
        fill_inc = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FW'(1);

        if (pat_load) begin
            // A new pattern invalidates history; the bit on x this cycle is dropped.
            pat_d  = pat_in;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = {hist_q[PAT_LEN-2:0], x};
            match  = (hist_d == pat_q) && (fill_inc == FILL_MAX);
            fill_d = (match && !overlap) ? '0 : fill_inc;
            z_d    = match;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= PAT_RESET;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match),
        .cnt   (match_cnt),
        .sat   (cnt_sat)
    );

    assign z = z_q;

endmodule

// File: doc/seq_pattern_detector.md
SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

Interface
REQ-001 Parameter PAT_LEN, default 6: pattern length in bits, legal range 2..32.
REQ-002 Parameter PAT_RESET, default 6'b110011: pattern loaded at reset; bit PAT_LEN-1 is the first serial bit.
REQ-003 Parameter CNT_W, default 8: width of the match counter, legal range 1..32.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port x, input, 1: serial data bit.
REQ-007 Port x_valid, input, 1: x is sampled only when this is 1.
REQ-008 Port overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 Port pat_load, input, 1: loads pat_in into the pattern register.
REQ-010 Port pat_in, input, PAT_LEN: new pattern value.
REQ-011 Port z, output, 1: registered Moore match flag.
REQ-012 Port match_cnt, output, CNT_W: saturating count of matches.
REQ-013 Port cnt_sat, output, 1: 1 when match_cnt equals all-ones.

Function
REQ-014 State: pattern register pat (PAT_LEN), history shift register hist (PAT_LEN), fill counter fill (0..PAT_LEN, saturating at PAT_LEN).
REQ-015 Edge with x_valid=1 and pat_load=0:
- hist <= {hist[PAT_LEN-2:0], x};
- fill <= min(fill+1, PAT_LEN).
REQ-016 A match occurs on that edge when the updated hist equals pat and the updated fill equals PAT_LEN.
REQ-017 z SHALL be 1 for exactly the one cycle following the edge that sampled the final pattern bit; 0 otherwise. Latency is one clock from sampling the last bit.
REQ-018 On a match with overlap=1, fill SHALL stay at PAT_LEN so the next bit can complete a further match.
REQ-019 On a match with overlap=0, fill SHALL be cleared to 0; hist is kept but not used until refilled.
REQ-020 Edge with x_valid=0 (and no pat_load): hist, fill and match_cnt hold; z <= 0.
REQ-021 On every match, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1; once saturated it holds until reset.
REQ-022 cnt_sat SHALL be combinationally equal to (match_cnt == all-ones).
REQ-023 pat_load=1 at an edge:
- pat <= pat_in; fill <= 0; z <= 0;
- x is ignored that cycle even if x_valid=1;
- match_cnt is unchanged.
REQ-024 overlap is sampled at the matching edge only; changing it mid-stream has no other effect.
REQ-025 Identical patterns that match themselves at every shift (e.g. all-ones) SHALL give z=1 on every valid bit after the first PAT_LEN when overlap=1.

Reset
REQ-026 When reset=1 at an edge:
- pat <= PAT_RESET; hist <= 0; fill <= 0;
- z <= 0; match_cnt <= 0.
REQ-027 Reset SHALL take priority over pat_load and x_valid.
REQ-028 Reset applied mid-pattern SHALL discard partial progress; a later match needs PAT_LEN fresh valid bits after reset is released.

Structure
REQ-029 Package seq_det_pkg SHALL hold the default PAT_LEN, PAT_RESET and CNT_W constants and the fill-counter width function clog2(PAT_LEN+1).
REQ-030 The saturating counter SHALL be a sub-module sat_counter (parameter W; inputs clk, reset, inc; outputs cnt, sat).

Verification
REQ-031 Defaults, overlap=1, valid bits 0,0,1,1,0,0,1,1,1,0,0,1,0,1,1,0 -> z=1 once, in the cycle after bit 8; final match_cnt=1.
REQ-032 Defaults, bits 1,1,0,0,1,1,0,0,1,1 -> overlap=1: z after bits 6 and 10, match_cnt=2; overlap=0: z after bit 6 only, match_cnt=1.
REQ-033 x_valid toggled 1/0 every cycle while sending 110011 -> exactly one z pulse, one cycle after the 6th valid bit; no z on idle cycles.
REQ-034 PAT_LEN=4, CNT_W=2, pattern 1111, overlap=1, 8 ones -> z on bits 4..8, match_cnt=3, cnt_sat=1 from the 3rd match onward.
REQ-035 reset=1 after bits 1,1,0,0,1, then 1 -> no z; then 110011 -> z once.
REQ-036 pat_load with pat_in=6'b101010 after bits 1,1,0 -> 110011 gives no z; 101010 gives z once; match_cnt holds across the load.
